// File: rtl/display_mux_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : display_mux_7seg
//  Description : Time-multiplexed 4-digit 7-segment driver. A prescaler
//                divides clk into a scan tick; one digit slot is shown per
//                tick. All four digits are snapshotted once per frame so a
//                digit update can never tear mid-scan.
//                Optional macro LZ_BLANK_EN enables leading-zero blanking,
//                evaluated on the snapshotted digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mux_7seg #(
    parameter int REFRESH_DIV  = 50000,  // clk cycles per digit slot (>=2)
    parameter int COMMON_ANODE = 1       // 1: sseg/an active-low, 0: active-high
) (
    input  logic       clk,
    input  logic       rst,              // asynchronous, active-low
    input  logic       en,
    input  logic [3:0] bcdunits,
    input  logic [3:0] bcdtens,
    input  logic [3:0] bcdcents,
    input  logic [3:0] bcdmils,
    output logic [6:0] sseg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    // XOR masks that turn active-high patterns into the board's drive level
    localparam logic [6:0]       c_seg_inv = {7{COMMON_ANODE != 0}};
    localparam logic [3:0]       c_an_inv  = {4{COMMON_ANODE != 0}};

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_sh_units;
    logic [3:0]       r_sh_tens;
    logic [3:0]       r_sh_cents;
    logic [3:0]       r_sh_mils;
    logic [6:0]       r_sseg;
    logic [3:0]       r_an;
    logic             r_frame_tick;

    logic             w_tick;
    logic             w_frame;
    logic [1:0]       w_next_idx;
    logic [3:0]       w_digit;
    logic [3:0]       w_onehot;
    logic             w_blank;

    // Active-high gfedcba decode; 10-15 shown as a dash
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b1000000;
        endcase
        return seg;
    endfunction

    // en has priority: a disabled cycle never ticks, even at the count limit
    assign w_tick     = en && (r_cnt == c_cnt_max);
    assign w_frame    = w_tick && (r_idx == 2'd3);
    // idx 3 wraps to 0, so this is also the slot selected at a frame boundary
    assign w_next_idx = r_idx + 2'd1;
    assign w_onehot   = 4'b0001 << w_next_idx;

    // Digit for the upcoming slot; the frame's units slot uses the live input
    // because the snapshot is being taken on that very edge
    always_comb begin
        w_digit = bcdunits;
        if (!w_frame) begin
            case (w_next_idx)
                2'd0:    w_digit = r_sh_units;
                2'd1:    w_digit = r_sh_tens;
                2'd2:    w_digit = r_sh_cents;
                default: w_digit = r_sh_mils;
            endcase
        end
    end

    // Leading-zero blanking of the upcoming slot, judged on the snapshot
    always_comb begin
        w_blank = 1'b0;
`ifdef LZ_BLANK_EN
        case (w_next_idx)
            2'd3:    w_blank = (r_sh_mils == 4'd0);
            2'd2:    w_blank = (r_sh_mils == 4'd0) && (r_sh_cents == 4'd0);
            2'd1:    w_blank = (r_sh_mils == 4'd0) && (r_sh_cents == 4'd0)
                               && (r_sh_tens == 4'd0);
            default: w_blank = 1'b0;
        endcase
`endif
    end

    // Prescaler, slot index and once-per-frame digit snapshot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_idx      <= 2'd3;
            r_sh_units <= 4'd0;
            r_sh_tens  <= 4'd0;
            r_sh_cents <= 4'd0;
            r_sh_mils  <= 4'd0;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= w_next_idx;
                if (w_frame) begin
                    r_sh_units <= bcdunits;
                    r_sh_tens  <= bcdtens;
                    r_sh_cents <= bcdcents;
                    r_sh_mils  <= bcdmils;
                end
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // Registered segment/anode drive; dark while disabled, held between ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sseg       <= c_seg_inv;
            r_an         <= c_an_inv;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame;
            if (!en) begin
                r_sseg <= c_seg_inv;
                r_an   <= c_an_inv;
            end else if (w_tick) begin
                r_sseg <= f_decode(w_digit) ^ c_seg_inv;
                r_an   <= w_blank ? c_an_inv : (w_onehot ^ c_an_inv);
            end
        end
    end

    assign sseg       = r_sseg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_mux_7seg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_display_mux_7seg
//  Description : Self-checking bench for display_mux_7seg (REFRESH_DIV=4,
//                common-anode). Honours LZ_BLANK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_mux_7seg;

    localparam int RD = 4;

    // Active-low segment patterns {g..a}
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [3:0] AOFF = 4'b1111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;
    logic [3:0] bu = 4'd0, bt = 4'd0, bc = 4'd0, bm = 4'd0;
    logic [6:0] sseg;
    logic [3:0] an;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] m, c, t, u;         // inputs
        logic [6:0] s0, s1, s2, s3;     // expected sseg for units..mils slots
        logic [3:0] lit;                // slots lit when blanking is enabled
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       chk_seg;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    always #5 clk = ~clk;

    display_mux_7seg #(
        .REFRESH_DIV (RD),
        .COMMON_ANODE(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bcdunits  (bu),
        .bcdtens   (bt),
        .bcdcents  (bc),
        .bcdmils   (bm),
        .sseg      (sseg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply inputs and queue the four slot results the next frame must show
    task automatic drive(input vec_t v);
        logic [6:0] segs[4];
        logic [3:0] one;
        logic       lit_eff;
        exp_t       e;
        bm = v.m; bc = v.c; bt = v.t; bu = v.u;
        segs[0] = v.s0; segs[1] = v.s1; segs[2] = v.s2; segs[3] = v.s3;
        one = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            lit_eff = 1'b1;
`ifdef LZ_BLANK_EN
            lit_eff = v.lit[s];
`endif
            e.an      = lit_eff ? ~(one << s) : AOFF;
            e.sseg    = segs[s];
            e.chk_seg = lit_eff;
            sb.push_back(e);
        end
    endtask

    task automatic wait_frame(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: frame_tick timeout, got none, expected pulse", name);
        end
    endtask

    task automatic check_slot(input string name, input int s);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty at slot %0d, expected entry", name, s);
            return;
        end
        e = sb.pop_front();
        check($sformatf("%s_an%0d", name, s), {12'd0, an}, {12'd0, e.an});
        if (e.chk_seg)
            check($sformatf("%s_seg%0d", name, s), {9'd0, sseg}, {9'd0, e.sseg});
        if (s > 0)
            check($sformatf("%s_ft%0d", name, s), {15'd0, frame_tick}, 16'd0);
    endtask

    task automatic check_frame(input string name);
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (RD) @(negedge clk);
            check_slot(name, s);
        end
    endtask

    task automatic check_dark(input string name);
        check({name, "_an"},  {12'd0, an},   {12'd0, AOFF});
        check({name, "_seg"}, {9'd0, sseg},  {9'd0, SOFF});
        check({name, "_ft"},  {15'd0, frame_tick}, 16'd0);
    endtask

    initial begin
        vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, S4, S3, S2, S1, 4'b1111};
        vecs[1] = '{4'h5, 4'h6, 4'h7, 4'h8, S8, S7, S6, S5, 4'b1111};
        vecs[2] = '{4'h9, 4'h0, 4'h1, 4'h2, S2, S1, S0, S9, 4'b1111};
        vecs[3] = '{4'h1, 4'h2, 4'hA, 4'h3, S3, SD, S2, S1, 4'b1111};
        vecs[4] = '{4'h0, 4'h0, 4'h0, 4'h7, S7, S0, S0, S0, 4'b0001};
        vecs[5] = '{4'h0, 4'h0, 4'h0, 4'h0, S0, S0, S0, S0, 4'b0001};
        vecs[6] = '{4'h0, 4'h1, 4'h0, 4'h0, S0, S0, S1, S0, 4'b0111};
        vecs[7] = '{4'hF, 4'hC, 4'h0, 4'hB, SD, S0, SD, SD, 4'b1111};

        // Reset state, then release: dark for RD cycles, frame on the RD-th edge
        bm = 4'h1; bc = 4'h2; bt = 4'h3; bu = 4'h4;
        @(negedge clk);
        check_dark("reset");
        rst = 1'b1;
        for (int k = 1; k <= RD; k++) begin
            @(negedge clk);
            if (k < RD) begin
                check_dark($sformatf("post_rst%0d", k));
            end else begin
                check("first_an",  {12'd0, an},  {12'd0, 4'b1110});
                check("first_seg", {9'd0, sseg}, {9'd0, S4});
                check("first_ft",  {15'd0, frame_tick}, 16'd1);
            end
        end
        @(negedge clk);
        check("ft_one_cycle", {15'd0, frame_tick}, 16'd0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            wait_frame($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i));
        end

        // Input change mid-frame stays invisible until the next frame
        drive(vecs[0]);
        wait_frame("midchg");
        check_slot("midchg", 0);
        repeat (RD) @(negedge clk);
        check_slot("midchg", 1);
        drive(vecs[1]);
        repeat (RD) @(negedge clk);
        check_slot("midchg", 2);
        repeat (RD) @(negedge clk);
        check_slot("midchg", 3);
        wait_frame("midchg_next");
        check_frame("midchg_next");

        // Enable dropped two cycles into slot 1, held low for 10 cycles
        wait_frame("endrop");
        repeat (RD) @(negedge clk);
        check("endrop_slot1_an",  {12'd0, an},  {12'd0, 4'b1101});
        check("endrop_slot1_seg", {9'd0, sseg}, {9'd0, S7});
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_dark($sformatf("en_off%0d", k));
        end
        en = 1'b1;
        @(negedge clk);
        check_dark("en_resume_dark");
        @(negedge clk);
        check("en_resume_an",  {12'd0, an},  {12'd0, 4'b1011});
        check("en_resume_seg", {9'd0, sseg}, {9'd0, S6});

        // Asynchronous reset mid-frame: immediate dark, restart as after power-up
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_dark("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= RD; k++) begin
            @(negedge clk);
            if (k < RD) begin
                check_dark($sformatf("midrst_rel%0d", k));
            end else begin
                check("midrst_an",  {12'd0, an},  {12'd0, 4'b1110});
                check("midrst_seg", {9'd0, sseg}, {9'd0, S8});
                check("midrst_ft",  {15'd0, frame_tick}, 16'd1);
            end
        end

        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
